// File: rtl/axi_wr_burst_scheduler.sv
// Round-robin AW/W scheduler with per-core outstanding limits and BID-routed B path; QOS_PRIORITY_EN adds QoS-first arbitration.
// Grant is registered one cycle after request and held to WLAST; cores stall via ready; the B path is combinational.
module axi_wr_burst_scheduler #(
  parameter int NUM_MASTERS     = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_MASTERS-1:0]   core_awvalid,
  input  logic [4*NUM_MASTERS-1:0] core_awqos,
  output logic [NUM_MASTERS-1:0]   core_awready,
  output logic                     noc_awvalid,
  input  logic                     noc_awready,
  input  logic [NUM_MASTERS-1:0]   core_wvalid,
  input  logic [NUM_MASTERS-1:0]   core_wlast,
  output logic [NUM_MASTERS-1:0]   core_wready,
  output logic                     noc_wvalid,
  input  logic                     noc_wready,
  output logic [2:0]               sel,
  input  logic                     noc_bvalid,
  input  logic [2:0]               noc_bid,
  output logic                     noc_bready,
  output logic [NUM_MASTERS-1:0]   core_bvalid,
  input  logic [NUM_MASTERS-1:0]   core_bready,
  output logic                     busy,
  output logic                     err_unexp_b
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                        state_q, state_d;
  logic [2:0]                    ptr_q, ptr_d;
  logic [2:0]                    sel_q, sel_d;
  logic [NUM_MASTERS-1:0]        grant_q, grant_d;
  logic [NUM_MASTERS-1:0][2:0]   ocnt_q, ocnt_d;
  logic                          err_q, err_d;

  logic [NUM_MASTERS-1:0]        full, eligible, cand;
  logic                          pick_vld;
  logic [2:0]                    pick_idx;
  logic                          aw_hs, w_hs, b_hs;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      full[i] = (ocnt_q[i] == 3'(MAX_OUTSTANDING));
    end
  end

  assign eligible = core_awvalid & ~full;

`ifdef QOS_PRIORITY_EN
  logic [3:0] max_qos;

  always_comb begin
    max_qos = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (eligible[i] && (core_awqos[4*i +: 4] > max_qos)) begin
        max_qos = core_awqos[4*i +: 4];
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand[i] = eligible[i] && (core_awqos[4*i +: 4] == max_qos);
    end
  end
`else
  logic unused_qos;
  assign unused_qos = ^core_awqos;
  assign cand       = eligible;
`endif

  // Scan downwards so the closest candidate at or after ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (cand[3'(ptr_q + 3'(i))]) begin
        pick_vld = 1'b1;
        pick_idx = ptr_q + 3'(i);
      end
    end
  end

  assign noc_awvalid  = (state_q == ADDR);
  assign core_awready = (state_q == ADDR) ? (grant_q & {NUM_MASTERS{noc_awready}}) : '0;
  assign noc_wvalid   = (state_q == DATA) && core_wvalid[sel_q];
  assign core_wready  = (state_q == DATA) ? (grant_q & {NUM_MASTERS{noc_wready}}) : '0;
  assign sel          = sel_q;

  assign aw_hs = noc_awvalid && noc_awready;
  assign w_hs  = noc_wvalid && noc_wready;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      core_bvalid[i] = noc_bvalid && (noc_bid == 3'(i));
    end
  end

  assign noc_bready  = core_bready[noc_bid];
  assign b_hs        = noc_bvalid && noc_bready;
  assign busy        = (state_q != IDLE) || (|ocnt_q);
  assign err_unexp_b = err_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          sel_d             = pick_idx;
          state_d           = ADDR;
        end
      end
      ADDR: begin
        if (aw_hs) begin
          ptr_d   = sel_q + 3'd1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs && core_wlast[sel_q]) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Same-cycle AW increment and B decrement on one core cancel out.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      ocnt_d[i] = ocnt_q[i];
      if ((aw_hs && (sel_q == 3'(i)) && !full[i]) &&
          !(b_hs && (noc_bid == 3'(i)) && (ocnt_q[i] != 3'd0))) begin
        ocnt_d[i] = ocnt_q[i] + 3'd1;
      end else if (!(aw_hs && (sel_q == 3'(i)) && !full[i]) &&
                   (b_hs && (noc_bid == 3'(i)) && (ocnt_q[i] != 3'd0))) begin
        ocnt_d[i] = ocnt_q[i] - 3'd1;
      end
    end
    err_d = err_q || (b_hs && (ocnt_q[noc_bid] == 3'd0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      ocnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      ocnt_q  <= ocnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_scheduler.sv
// Scoreboard bench for axi_wr_burst_scheduler: expected grant order and burst lengths are queued at stimulus time.
module tb_axi_wr_burst_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  core_awvalid, core_awready, core_wvalid, core_wlast, core_wready;
  logic [31:0] core_awqos;
  logic        noc_awvalid, noc_awready, noc_wvalid, noc_wready;
  logic [2:0]  sel, noc_bid;
  logic        noc_bvalid, noc_bready;
  logic [7:0]  core_bvalid, core_bready;
  logic        busy, err_unexp_b;

  axi_wr_burst_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .core_awvalid(core_awvalid), .core_awqos(core_awqos), .core_awready(core_awready),
    .noc_awvalid(noc_awvalid), .noc_awready(noc_awready),
    .core_wvalid(core_wvalid), .core_wlast(core_wlast), .core_wready(core_wready),
    .noc_wvalid(noc_wvalid), .noc_wready(noc_wready), .sel(sel),
    .noc_bvalid(noc_bvalid), .noc_bid(noc_bid), .noc_bready(noc_bready),
    .core_bvalid(core_bvalid), .core_bready(core_bready),
    .busy(busy), .err_unexp_b(err_unexp_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_sel[$];
  int exp_len[$];
  int aw_pend[8], w_todo[8], w_beat[8], blen[8], ocnt_m[8];
  int cyc = 0, owner = -1, beats = 0, last_wlast_cyc = -1;
  bit gap_chk = 1'b0;
  bit err_m = 1'b0;
  logic [7:0] awh, wh;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    int e;
    awh = core_awready & core_awvalid;
    wh  = core_wready & core_wvalid;
    if (noc_awvalid && noc_awready) begin
      if (exp_sel.size() == 0) begin
        chk("aw_unexpected", exp_sel.size(), 1);
      end else begin
        e = exp_sel.pop_front();
        chk("aw_sel", sel, e);
        chk("aw_ready_onehot", core_awready, 8'b1 << e);
        if (gap_chk && last_wlast_cyc >= 0) chk("burst_bubble", cyc - last_wlast_cyc, 2);
        owner = e;
        ocnt_m[e]++;
      end
    end
    if (noc_wvalid && noc_wready) begin
      chk("w_sel", sel, owner);
      chk("w_ready_onehot", core_wready, 8'b1 << owner);
      beats++;
      if (core_wlast[sel]) begin
        if (exp_len.size() == 0) chk("w_unexpected", exp_len.size(), 1);
        else chk("burst_len", beats, exp_len.pop_front());
        beats = 0;
        last_wlast_cyc = cyc;
      end
    end
    if (noc_bvalid && noc_bready) begin
      if (ocnt_m[noc_bid] > 0) ocnt_m[noc_bid]--;
      else err_m = 1'b1;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 8; i++) begin
      core_awvalid[i] = (aw_pend[i] > 0);
      core_wvalid[i]  = (w_todo[i] > 0);
      core_wlast[i]   = (w_beat[i] == blen[i] - 1);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      if (awh[i]) aw_pend[i]--;
      if (wh[i]) begin
        w_todo[i]--;
        w_beat[i] = (w_beat[i] == blen[i] - 1) ? 0 : w_beat[i] + 1;
      end
    end
    drive();
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n = 0;
    while ((exp_sel.size() != 0 || exp_len.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    chk(tag, exp_sel.size() + exp_len.size(), 0);
  endtask

  task automatic send_b(input logic [2:0] id);
    noc_bvalid  = 1'b1;
    noc_bid     = id;
    core_bready = 8'b1 << id;
    #1;
    chk("b_route", core_bvalid, 8'b1 << id);
    chk("b_ready", noc_bready, 1);
    tick();
    noc_bvalid  = 1'b0;
    core_bready = '0;
  endtask

  task automatic queue_burst(input int core, input int n, input int len);
    aw_pend[core] += n;
    w_todo[core]  += n * len;
    blen[core]     = len;
    for (int k = 0; k < n; k++) begin
      exp_sel.push_back(core);
      exp_len.push_back(len);
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < 8; i++) begin
      aw_pend[i] = 0; w_todo[i] = 0; w_beat[i] = 0; blen[i] = 1; ocnt_m[i] = 0;
    end
    exp_sel.delete();
    exp_len.delete();
    owner = -1; beats = 0; last_wlast_cyc = -1; err_m = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    core_awqos = '0; noc_awready = 1'b1; noc_wready = 1'b1;
    noc_bvalid = 1'b0; noc_bid = '0; core_bready = '0;
    clear_models();
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", noc_awvalid, 0);
    chk("rst_wvalid", noc_wvalid, 0);
    chk("rst_awready", core_awready, 0);
    chk("rst_wready", core_wready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_unexp_b, 0);
    chk("rst_sel", sel, 0);
    chk("rst_bvalid", core_bvalid, 0);
    rst_n = 1'b1;

    // Three simultaneous 2-beat requesters.
    gap_chk = 1'b1;
    queue_burst(0, 1, 2);
    queue_burst(3, 1, 2);
    queue_burst(7, 1, 2);
    drive();
    wait_drain("rr_drain", 100);
    gap_chk = 1'b0;

    // Outstanding limit: fifth single-beat write waits for a B.
    queue_burst(2, 4, 1);
    aw_pend[2] = 5;
    w_todo[2]  = 5;
    drive();
    wait_drain("full_first4", 100);
    repeat (5) tick();
    chk("full_awvalid", noc_awvalid, 0);
    chk("full_pending", aw_pend[2], 1);
    exp_sel.push_back(2);
    exp_len.push_back(1);
    send_b(3'd2);
    chk("unblock_early", core_awready, 0);
    tick();
    chk("unblock_awready", core_awready, 8'h04);
    wait_drain("unblock_drain", 20);

    // Early W data and W backpressure.
    noc_awready = 1'b0;
    queue_burst(1, 1, 4);
    drive();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("early_w_stall", core_wready, 0);
    end
    chk("addr_hold", noc_awvalid, 1);
    noc_awready = 1'b1;
    for (int k = 0; k < 30 && exp_len.size() != 0; k++) begin
      tick();
      noc_wready = ~noc_wready;
    end
    noc_wready = 1'b1;
    chk("w4_done", exp_len.size(), 0);
    chk("w4_beats_left", w_todo[1], 0);

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8 && ocnt_m[i] > 0; k++) send_b(3'(i));
    end
    chk("busy_drained", busy, 0);

    // Unexpected B for an idle core.
    send_b(3'd5);
    chk("err_unexp", err_unexp_b, err_m);
    chk("err_set", err_unexp_b, 1);
    chk("no_underflow", busy, 0);

    // Reset in the middle of a 4-beat burst.
    queue_burst(4, 1, 4);
    drive();
    for (int k = 0; k < 20 && w_todo[4] > 2; k++) tick();
    chk("mid_burst", w_todo[4], 2);
    chk("mid_burst_wvalid", noc_wvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wvalid", noc_wvalid, 0);
    chk("arst_wready", core_wready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sel", sel, 0);
    chk("arst_err", err_unexp_b, 0);
    chk("arst_awvalid", noc_awvalid, 0);
    clear_models();
    drive();
    tick();
    tick();
    rst_n = 1'b1;

    // First request after reset: ptr is 0 again.
    core_awqos[7:4]   = 4'd2;
    core_awqos[27:24] = 4'd9;
`ifdef QOS_PRIORITY_EN
    queue_burst(6, 1, 1);
    queue_burst(1, 1, 1);
`else
    queue_burst(1, 1, 1);
    queue_burst(6, 1, 1);
`endif
    drive();
    wait_drain("post_rst_drain", 50);
    chk("post_rst_err", err_unexp_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_wr_burst_scheduler.md
# axi_wr_burst_scheduler

Write-channel scheduler for the A78AE cluster's 8-to-1 ACE interconnect. It shares the single NoC AW/W port among eight cores with round-robin arbitration and holds the grant across the whole W burst until WLAST, so write data is never interleaved. It also limits each core's outstanding writes and steers B responses back to the issuing core by BID. The payload muxes stay in the interconnect; this block only drives select, valid and ready.

## Interface
- NUM_MASTERS, 8, number of requesting cores; fixed at 8 in this revision.
- MAX_OUTSTANDING, 4, maximum un-acknowledged writes per core; range 1..7.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- core_awvalid  in  8  AW request per core.
- core_awqos  in  32  per-core AWQOS, 4 bits each; used only with QOS_PRIORITY_EN.
- core_awready  out  8  one-hot AW accept to the granted core.
- noc_awvalid  out  1  AW valid to the NoC.
- noc_awready  in  1  NoC AW ready.
- core_wvalid  in  8  W valid per core.
- core_wlast  in  8  W last per core.
- core_wready  out  8  one-hot W ready to the granted core.
- noc_wvalid  out  1  W valid to the NoC.
- noc_wready  in  1  NoC W ready.
- sel  out  3  binary index of the granted core; drives the AW/W payload mux.
- noc_bvalid  in  1  B valid from the NoC.
- noc_bid  in  3  BID[2:0]; identifies the destination core.
- noc_bready  out  1  B ready to the NoC.
- core_bvalid  out  8  B valid per core.
- core_bready  in  8  B ready per core.
- busy  out  1  high in every state other than IDLE, or while any outstanding counter is non-zero.
- err_unexp_b  out  1  sticky flag; set by a B handshake for a core whose counter is 0.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - eligible = core_awvalid & ~full, where full[i] = (ocnt[i] == MAX_OUTSTANDING).
  - Round-robin pick: the first eligible index at or above ptr, wrapping modulo 8.
  - If any core is eligible, register the one-hot grant and sel, then go to ADDR. Otherwise stay in IDLE.
- ADDR:
  - noc_awvalid = 1; core_awready = grant & noc_awready.
  - On AW handshake (noc_awvalid & noc_awready): ocnt[sel]++, ptr <= sel+1 (mod 8), go to DATA.
- DATA:
  - noc_wvalid = core_wvalid[sel]; core_wready = grant & noc_wready.
  - A handshake with core_wlast[sel] = 1 clears the grant and returns to IDLE.
  - A single-beat burst (WLAST on the first beat) is legal.
- W beats are accepted only in DATA. core_wready is 0 in IDLE and ADDR, so early W data from a core stalls.
- B routing is combinational:
  - core_bvalid = onehot(noc_bid) & {8{noc_bvalid}}.
  - noc_bready = core_bready[noc_bid].
- A B handshake decrements ocnt[noc_bid]. A simultaneous AW increment and B decrement on the same core leaves that counter unchanged.
- If a B handshake arrives for a core whose counter is 0: the counter does not underflow and err_unexp_b is set. It is cleared only by reset.
- Counters are 3 bits wide and saturate at MAX_OUTSTANDING; a full core is masked from arbitration.
- A core's awvalid falling while it holds the grant in ADDR is a protocol violation by the core. The scheduler keeps noc_awvalid asserted regardless.

## Timing
- Reset values:
  - State IDLE; ptr = 0; every ocnt = 0; grant = 0; sel = 0.
  - noc_awvalid, noc_wvalid, core_awready, core_wready, busy, err_unexp_b = 0.
  - core_bvalid and noc_bready follow their combinational inputs.
- Reset applied mid-burst aborts to IDLE immediately and clears all outstanding counters.
- AW request is sampled in cycle N. Grant, sel and noc_awvalid are registered and appear in cycle N+1.
- A WLAST handshake in cycle M returns the FSM to IDLE in cycle M+1. The next grant is visible in M+2, giving one bubble between bursts.
- The B path has zero latency and no state other than the counter update.

## Configuration
- QOS_PRIORITY_EN:
  - Defined: in IDLE, only eligible cores carrying the maximum core_awqos value among eligible cores compete. Round-robin from ptr breaks ties.
  - Undefined: core_awqos is ignored and arbitration is pure round-robin.

## Test plan
- Cores 0, 3 and 7 request simultaneously, 2-beat bursts, noc_awready and noc_wready held at 1. Required: grant order 0, 3, 7; sel = 0, 3, 7; no W interleave; one-cycle bubble between bursts.
- Core 2 issues 5 single-beat writes with MAX_OUTSTANDING = 4 and no B responses. Required: the 5th AW is blocked. A B handshake with bid = 2 unblocks it; core_awready[2] rises 2 cycles later.
- Core 1 drives W beats before its AW is granted, and noc_wready toggles 1,0,1 during DATA. Required: core_wready = 0 until DATA; exactly 4 beats transfer for awlen = 3.
- B arrives with bid = 5 while ocnt[5] = 0. Required: core_bvalid = 8'b0010_0000; err_unexp_b = 1; ocnt[5] stays 0.
- With QOS_PRIORITY_EN defined: core 1 requests at qos 2 and core 6 at qos 9, with ptr = 0. Required: core 6 is granted first.
- rst_n is asserted in DATA after 2 of 4 beats. Required: all outputs return to their reset values asynchronously; ocnt all 0; next request is granted cleanly.
